// File: rtl/uart_rx_core_pkg.sv
// rtl/uart_rx_core_pkg.sv - shared state encoding and sampling helper for uart_rx_core
package uart_rx_core_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fallthrough receive FIFO, extra pointer bit separates full from empty
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - configurable oversampling UART receiver with majority vote and receive FIFO
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  input  logic                 err_clear,
  output logic                 busy
);
  localparam int SCW    = $clog2(OVERSAMPLE);
  localparam int MID    = OVERSAMPLE / 2;
  localparam int FE_BIT = DATA_BITS;
  localparam int PE_BIT = DATA_BITS + 1;
  localparam int EW     = DATA_BITS + 2;

  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || OVERSAMPLE > 32 ||
      (OVERSAMPLE % 2) != 0 || STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_rx_core: parameter out of range");
  end

  logic [1:0]           sync_q, sync_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  rx_state_e            state_q, state_d;
  logic [SCW-1:0]       sc_q, sc_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 armed_q, armed_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 push_q, push_d;
  logic [EW-1:0]        entry_q, entry_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic                 rxs, tick, maj, maj_pt, bit_end, frame_err_next;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [EW-1:0]        fifo_dout;

  assign rxs            = sync_q[1];
  assign tick           = (div_cnt_q >= divisor);
  assign maj            = majority3(samp_q[0], samp_q[1], rxs);
  assign maj_pt         = tick && (sc_q == SCW'(MID + 1));
  assign bit_end        = tick && (sc_q == SCW'(OVERSAMPLE - 1));
  assign frame_err_next = frame_err_q | ~maj;
  assign fifo_pop       = !fifo_empty && rx_ready;

  always_comb begin
    sync_d       = {sync_q[0], rx};
    div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
    state_d      = state_q;
    sc_d         = sc_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    armed_d      = armed_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    push_d       = 1'b0;
    entry_d      = entry_q;
    overrun_d    = overrun_q;

    if (tick && state_q != S_IDLE) sc_d = bit_end ? '0 : sc_q + 1'b1;
    if (tick && sc_q == SCW'(MID - 1)) samp_d[0] = rxs;
    if (tick && sc_q == SCW'(MID)) samp_d[1] = rxs;

    case (state_q)
      S_IDLE: begin
        // armed needs a high line first, so a held-low break cannot retrigger.
        if (rxs) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d      = S_START;
          armed_d      = 1'b0;
          sc_d         = '0;
          div_cnt_d    = '0;
          bit_cnt_d    = '0;
          stop_cnt_d   = 1'b0;
          parity_err_d = 1'b0;
          frame_err_d  = 1'b0;
        end
      end
      S_START: begin
        if (maj_pt && maj) state_d = S_IDLE;
        else if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (maj_pt) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == 4'(DATA_BITS - 1)) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          else bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      S_PARITY: begin
        if (maj_pt) parity_err_d = ((^shift_q) ^ maj) != (PARITY_ODD != 0);
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (maj_pt) begin
          frame_err_d = frame_err_next;
          // Leave at mid-bit of the last stop so a back-to-back start edge is not missed.
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            push_d  = 1'b1;
            entry_d = {parity_err_q, frame_err_next, shift_q};
            state_d = S_IDLE;
          end
        end
        if (bit_end) stop_cnt_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    if (err_clear) overrun_d = 1'b0;
    if (push_q && fifo_full && !fifo_pop) overrun_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync_q       <= 2'b11;
      div_cnt_q    <= '0;
      state_q      <= S_IDLE;
      sc_q         <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      armed_q      <= 1'b0;
      samp_q       <= '0;
      shift_q      <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      push_q       <= 1'b0;
      entry_q      <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      div_cnt_q    <= div_cnt_d;
      state_q      <= state_d;
      sc_q         <= sc_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      armed_q      <= armed_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      push_q       <= push_d;
      entry_q      <= entry_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetb (resetb),
    .push   (push_q),
    .din    (entry_q),
    .full   (fifo_full),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .empty  (fifo_empty)
  );

  assign rx_valid      = !fifo_empty;
  assign rx_data       = fifo_empty ? '0 : fifo_dout[DATA_BITS-1:0];
  assign rx_frame_err  = !fifo_empty && fifo_dout[FE_BIT];
  assign rx_parity_err = !fifo_empty && fifo_dout[PE_BIT];
  assign overrun       = overrun_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed self-checking bench for uart_rx_core (8N1 and 7E2 instances)
module tb_uart_rx_core;

  logic        clock = 1'b0;
  logic        resetb;
  logic [15:0] divisor;
  logic        rx_a, rx_b;
  logic        rx_ready_a, err_clear;
  logic        rx_ready_b = 1'b1;
  logic [7:0]  rx_data_a;
  logic [6:0]  rx_data_b;
  logic        fe_a, pe_a, valid_a, overrun_a, busy_a;
  logic        fe_b, pe_b, valid_b, overrun_b, busy_b;

  int          checks = 0;
  int          errors = 0;
  int          bit_ns;
  logic [10:0] qa[$];
  logic [10:0] qb[$];

  always #10 clock = ~clock;

  uart_rx_core dut_a (
    .clock(clock), .resetb(resetb), .divisor(divisor), .rx(rx_a),
    .rx_data(rx_data_a), .rx_frame_err(fe_a), .rx_parity_err(pe_a),
    .rx_valid(valid_a), .rx_ready(rx_ready_a), .overrun(overrun_a),
    .err_clear(err_clear), .busy(busy_a)
  );

  uart_rx_core #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
    .clock(clock), .resetb(resetb), .divisor(divisor), .rx(rx_b),
    .rx_data(rx_data_b), .rx_frame_err(fe_b), .rx_parity_err(pe_b),
    .rx_valid(valid_b), .rx_ready(rx_ready_b), .overrun(overrun_b),
    .err_clear(err_clear), .busy(busy_b)
  );

  // Every accepted pop is logged as {parity_err, frame_err, data zero-extended to 9 bits}.
  always @(posedge clock) begin
    if (resetb && valid_a && rx_ready_a) qa.push_back({pe_a, fe_a, 1'b0, rx_data_a});
    if (resetb && valid_b && rx_ready_b) qb.push_back({pe_b, fe_b, 2'b00, rx_data_b});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_a(input string tag, input logic [10:0] exp);
    logic [31:0] got;
    if (qa.size() > 0) got = 32'(qa.pop_front());
    else got = 32'hffff_ffff;
    check_eq(tag, got, 32'(exp));
  endtask

  task automatic expect_b(input string tag, input logic [10:0] exp);
    logic [31:0] got;
    if (qb.size() > 0) got = 32'(qb.pop_front());
    else got = 32'hffff_ffff;
    check_eq(tag, got, 32'(exp));
  endtask

  // par < 0 means no parity bit; the line is left at the last stop-bit level.
  task automatic send_frame(input bit to_b, input logic [8:0] data, input int nbits,
                            input int par, input logic stop1, input int nstop, input logic stop2);
    logic v;
    for (int k = 0; k < nbits + 4; k++) begin
      if (k == 0) v = 1'b0;
      else if (k <= nbits) v = data[k-1];
      else if (k == nbits + 1) begin
        if (par < 0) continue;
        v = par[0];
      end
      else if (k == nbits + 2) v = stop1;
      else begin
        if (nstop != 2) continue;
        v = stop2;
      end
      if (to_b) rx_b = v;
      else rx_a = v;
      #(bit_ns);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
    $fatal(1);
  end

  initial begin
    resetb = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rx_ready_a = 1'b1; err_clear = 1'b0;
    divisor = 16'd26; bit_ns = 8680;
    repeat (5) @(posedge clock);
    #1;
    check_eq("reset rx_valid", valid_a, 0);
    check_eq("reset rx_data", rx_data_a, 0);
    check_eq("reset flags", {fe_a, pe_a, overrun_a}, 0);
    check_eq("reset busy", busy_a, 0);
    resetb = 1'b1;
    repeat (20) @(posedge clock);
    #1;

    // Nominal 8N1 at 115200 baud on a 50 MHz clock.
    fork
      send_frame(0, 9'h37, 8, -1, 1'b1, 1, 1'b1);
      begin
        repeat (2) @(posedge clock);
        #1 check_eq("busy 2 clk after edge", busy_a, 0);
        @(posedge clock);
        #1 check_eq("busy 3 clk after edge", busy_a, 1);
      end
    join
    check_eq("nominal busy after frame", busy_a, 0);
    #(bit_ns);
    check_eq("nominal count", qa.size(), 1);
    expect_a("nominal 0x37", {1'b0, 1'b0, 9'h037});
    check_eq("nominal valid idle", valid_a, 0);

    // Faster bit clock for the rest; divisor changed while idle.
    divisor = 16'd3;
    bit_ns = 1318;
    send_frame(0, 9'h0C3, 8, -1, 1'b1, 1, 1'b1);
    #(bit_ns);
    bit_ns = 1242;
    send_frame(0, 9'h03C, 8, -1, 1'b1, 1, 1'b1);
    #(bit_ns);
    bit_ns = 1280;
    expect_a("slow baud 0xC3", {1'b0, 1'b0, 9'h0C3});
    expect_a("fast baud 0x3C", {1'b0, 1'b0, 9'h03C});

    // False start: low for four ticks only.
    rx_a = 1'b0;
    #320;
    check_eq("false start busy", busy_a, 1);
    rx_a = 1'b1;
    #(bit_ns / 2);
    check_eq("false start idle", busy_a, 0);
    #(bit_ns);
    check_eq("false start no push", qa.size(), 0);
    check_eq("false start valid", valid_a, 0);

    // Framing error followed by a 20-bit break, then a clean character.
    send_frame(0, 9'h055, 8, -1, 1'b0, 1, 1'b1);
    #(20 * bit_ns);
    rx_a = 1'b1;
    #(2 * bit_ns);
    check_eq("break count", qa.size(), 1);
    expect_a("break 0x55 frame_err", {1'b0, 1'b1, 9'h055});
    send_frame(0, 9'h00A, 8, -1, 1'b1, 1, 1'b1);
    #(bit_ns);
    expect_a("after break 0x0A", {1'b0, 1'b0, 9'h00A});
    check_eq("after break extra", qa.size(), 0);

    // 7E2 instance: 0x37 has five ones, so the even-parity bit is 1.
    send_frame(1, 9'h037, 7, 0, 1'b1, 2, 1'b1);
    send_frame(1, 9'h037, 7, 1, 1'b1, 2, 1'b1);
    send_frame(1, 9'h037, 7, 1, 1'b1, 2, 1'b0);
    rx_b = 1'b1;
    #(2 * bit_ns);
    send_frame(1, 9'h037, 7, 0, 1'b0, 2, 1'b1);
    #(bit_ns);
    check_eq("parity count", qb.size(), 4);
    expect_b("parity bad bit", {1'b1, 1'b0, 9'h037});
    expect_b("parity good bit", {1'b0, 1'b0, 9'h037});
    expect_b("second stop low", {1'b0, 1'b1, 9'h037});
    expect_b("parity and stop1", {1'b1, 1'b1, 9'h037});
    check_eq("7E2 idle", {busy_b, overrun_b}, 0);

    // Overrun: five characters into a four-deep FIFO with no consumer.
    @(negedge clock);
    rx_ready_a = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(0, 9'(48 + i), 8, -1, 1'b1, 1, 1'b1);
    #(bit_ns);
    check_eq("overrun set", overrun_a, 1);
    check_eq("overrun head", rx_data_a, 8'h30);
    @(negedge clock);
    rx_ready_a = 1'b1;
    repeat (8) @(negedge clock);
    check_eq("overrun drained", qa.size(), 4);
    for (int i = 0; i < 4; i++) expect_a("overrun pop", 11'(48 + i));
    check_eq("overrun empty", valid_a, 0);
    check_eq("overrun sticky", overrun_a, 1);
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    check_eq("overrun cleared", overrun_a, 0);

    // Same again, but the consumer pops in the cycle the fifth entry is pushed.
    rx_ready_a = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(0, 9'(48 + i), 8, -1, 1'b1, 1, 1'b1);
    fork
      send_frame(0, 9'h034, 8, -1, 1'b1, 1, 1'b1);
      begin
        int n = 0;
        while (dut_a.push_q !== 1'b1 && n < 2000) begin
          @(negedge clock);
          n++;
        end
        check_eq("fifth push seen", n < 2000, 1);
        rx_ready_a = 1'b1;
        @(negedge clock);
        rx_ready_a = 1'b0;
      end
    join
    #(bit_ns);
    check_eq("push+pop overrun", overrun_a, 0);
    check_eq("push+pop one pop", qa.size(), 1);
    @(negedge clock);
    rx_ready_a = 1'b1;
    repeat (8) @(negedge clock);
    for (int i = 0; i < 5; i++) expect_a("push+pop drain", 11'(48 + i));
    check_eq("push+pop empty", valid_a, 0);

    // Reset in data bit 4 of 0xA5 with an entry already waiting.
    rx_ready_a = 1'b0;
    send_frame(0, 9'h011, 8, -1, 1'b1, 1, 1'b1);
    #(bit_ns);
    check_eq("pre-reset valid", valid_a, 1);
    fork
      send_frame(0, 9'h0A5, 8, -1, 1'b1, 1, 1'b1);
      begin
        #(5 * bit_ns + bit_ns / 2);
        @(negedge clock);
        resetb = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("mid reset valid/data", {valid_a, rx_data_a}, 0);
        check_eq("mid reset flags", {fe_a, pe_a, overrun_a}, 0);
        check_eq("mid reset busy", busy_a, 0);
        resetb = 1'b1;
      end
    join
    #(12 * bit_ns);
    @(negedge clock);
    rx_ready_a = 1'b1;
    repeat (4) @(negedge clock);
    qa.delete();
    send_frame(0, 9'h03C, 8, -1, 1'b1, 1, 1'b1);
    #(bit_ns);
    check_eq("post reset count", qa.size(), 1);
    expect_a("post reset 0x3C", {1'b0, 1'b0, 9'h03C});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
